mac_window_feeder: RTL and testbench
====================================

# mac_window_feeder

Synthesizable streaming source for the 3x3 convolution `mac` datapath. It issues sequential reads to the packed image/weight column memories and captures the returned 24-bit column words. It builds the sliding 3x3 pixel and kernel windows and presents one window per returned column, with `o_valid` asserted once three columns are resident. It sits between the column SRAMs and the `mac` inputs (`i_im*`, `i_ker*`, `i_valid`).

## Interface
- `N`, 128: columns per frame (memory words read); must be >= 3, elaboration error otherwise.
- `AW`, 17: memory address width.
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low. Clock `clk`.
- `i_start` in 1: frame start request; sampled only in IDLE.
- `i_hold` in 1: downstream inhibit; blocks issue of new reads.
- `o_busy` out 1: high in FETCH and DRAIN.
- `o_done` out 1: one-cycle pulse when the frame's last window is presented.
- `o_mem_en` out 1: registered read enable to both column memories.
- `o_mem_addr` out AW: registered read address, 0..N-1.
- `i_img_data` in 24: image word, 1-cycle synchronous read latency. Rows are `[7:0]`, `[15:8]`, `[23:16]`.
- `i_wgt_data` in 24: weight word, same latency. Rows are `[3:0]`, `[11:8]`, `[19:16]`; other bits ignored.
- `o_im` out 72: pixels `im1..im9`, where `im(k+1) = o_im[8k+7:8k]`.
- `o_ker` out 36: kernels `ker1..ker9`, where `ker(k+1) = o_ker[4k+3:4k]`.
- `o_valid` out 1: current `o_im`/`o_ker` is a complete window.

## Operation
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE -> FETCH on `i_start`.
  - FETCH -> DRAIN after the read of address N-1 is issued.
  - DRAIN -> IDLE on the shift of column N-1, with `o_done` pulsed.
- Read issue:
  - `o_mem_en <= (state==FETCH or start accepted) && !i_hold`.
  - Address starts at 0 and increments by 1 per issued read. No wrap; it stops at N-1.
- Return tracking: `rd_v <= o_mem_en`. When `rd_v`=1, the column shifts into the window, independent of `i_hold`.
- Window shift, per row r in {1,2,3}, with base b = 3(r-1):
  - `im(b+1) <= im(b+2)`, `im(b+2) <= im(b+3)`, `im(b+3) <= row r` of `i_img_data`.
  - The kernel shifts identically from `i_wgt_data`.
- Column counter:
  - Cleared on accepted start; +1 per shift, saturating at 3.
  - `o_valid <= rd_v && (col_cnt >= 2)`.
  - N-2 valid windows per frame.
- Accepted start also clears all window registers to 0.
- `i_start` in FETCH or DRAIN is ignored. A start coincident with `o_done` is ignored, since the state is not yet IDLE.
- Reset, including mid-frame: state IDLE; every output 0 (`o_busy`, `o_done`, `o_mem_en`, `o_mem_addr`, `o_im`, `o_ker`, `o_valid`); `rd_v`=0, `col_cnt`=0. In-flight read data returning after reset is discarded.

## Timing
- Edge E0 samples `i_start` in IDLE with `i_hold`=0. After E0: `o_mem_en`=1, `o_mem_addr`=0, `o_busy`=1.
- With no hold, addresses 0..N-1 are driven after E0..E(N-1); `o_mem_en` drops after EN.
- Column c shifts at E(c+2).
- `o_valid` is first high after E4 (column 2) and last high after E(N+1).
- `o_done`=1 for the single cycle after E(N+1). `o_busy` drops after E(N+1).
- Each hold cycle in FETCH delays all later reads by one cycle. A read already issued still returns and shifts.
- `o_valid` is never asserted during a cycle with no shift. Windows are never repeated.

## Configuration
- `FEEDER_PERF_CNT_EN` defined:
  - Adds port `o_hold_cycles` out 16.
  - Counts cycles with state==FETCH && `i_hold`=1, saturating at 16'hFFFF.
  - Cleared on reset and on accepted start.
- Not defined: port and counter are absent; all other behaviour is identical.

## Test plan
- Ramp, N=8:
  - Stimulus: image word c = {c+2, c+1, c}; weight word c = {4'h3, 4'h2, 4'h1} in the row lanes.
  - Response: exactly 6 `o_valid` pulses after E4..E9.
  - First window: `im1..im3` = 0,1,2; `im4..im6` = 1,2,3; `im7..im9` = 2,3,4.
  - `o_done` after E9; addresses 0..7 each issued once.
- Hold:
  - Stimulus: N=8, `i_hold`=1 for 3 cycles after E2.
  - Response: address 2 issued after E5. `o_valid` count still 6, with the same window contents as the ramp test, in order. `o_done` 3 cycles later (after E12).
- Reset mid-frame:
  - Stimulus: `rstn`=0 at E5.
  - Response: all outputs 0 next cycle, state IDLE.
  - Follow-up: a restart produces a full, correct frame with no stale window.
- Start while busy:
  - Stimulus: `i_start` pulsed at E3 and coincident with `o_done`.
  - Response: both ignored; exactly one frame runs.
- Back-to-back:
  - Stimulus: `i_start` the cycle after `o_done`.
  - Response: second frame `o_valid` count N-2; its first window contains no columns from frame 1.
- `FEEDER_PERF_CNT_EN`:
  - Stimulus: 5 hold cycles in FETCH plus 2 hold cycles in IDLE.
  - Response: `o_hold_cycles`=5.

Source files
------------

// File: rtl/mac_window_feeder_if.sv
// Column-memory read port and 3x3 window output bundle between mac_window_feeder and its neighbours.
// The master modport is the feeder side; the slave modport is the SRAM/mac side.
interface mac_window_feeder_if #(
  parameter int AW = 17
);
  logic          o_mem_en;
  logic [AW-1:0] o_mem_addr;
  logic [23:0]   i_img_data;
  logic [23:0]   i_wgt_data;
  logic [71:0]   o_im;
  logic [35:0]   o_ker;
  logic          o_valid;

  modport master (
    output o_mem_en, o_mem_addr, o_im, o_ker, o_valid,
    input  i_img_data, i_wgt_data
  );

  modport slave (
    input  o_mem_en, o_mem_addr, o_im, o_ker, o_valid,
    output i_img_data, i_wgt_data
  );
endinterface

// File: rtl/mac_window_feeder.sv
// Reads N image/weight columns and slides 3x3 windows into mac; o_valid 2 cycles after each column read once 3 are resident.
// i_hold stalls only new reads (in-flight columns still shift); FEEDER_PERF_CNT_EN adds the o_hold_cycles counter.
module mac_window_feeder #(
  parameter int N  = 128,
  parameter int AW = 17
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_start,
  input  logic        i_hold,
  output logic        o_busy,
  output logic        o_done,
`ifdef FEEDER_PERF_CNT_EN
  output logic [15:0] o_hold_cycles,
`endif
  mac_window_feeder_if.master bus
);

  if (N < 3) begin : g_bad_n
    $error("mac_window_feeder: N must be >= 3");
  end

  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e        state_q, state_d;
  logic          start_acc, issue, last_shift;
  logic [AW-1:0] issue_addr;
  logic [AW-1:0] next_addr_q;
  logic [AW-1:0] mem_addr_q;
  logic          mem_en_q;
  logic          rd_v_q;
  logic [1:0]    col_cnt_q;
  logic [71:0]   im_q;
  logic [35:0]   ker_q;
  logic          valid_q;
  logic          done_q;

  always_comb begin
    state_d    = state_q;
    start_acc  = 1'b0;
    // Last column is in flight once nothing further is being read.
    last_shift = (state_q == DRAIN) && rd_v_q && !mem_en_q;
    case (state_q)
      IDLE:    if (i_start) begin
                 start_acc = 1'b1;
                 state_d   = FETCH;
               end
      FETCH:   if (!i_hold && next_addr_q == LAST_ADDR) state_d = DRAIN;
      DRAIN:   if (last_shift) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    issue      = ((state_q == FETCH) || start_acc) && !i_hold;
    issue_addr = start_acc ? '0 : next_addr_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      next_addr_q <= '0;
      rd_v_q      <= 1'b0;
      col_cnt_q   <= 2'd0;
      im_q        <= '0;
      ker_q       <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mem_en_q <= issue;
      if (issue) begin
        mem_addr_q  <= issue_addr;
        next_addr_q <= issue_addr + AW'(1);
      end else if (start_acc) begin
        mem_addr_q  <= '0;
        next_addr_q <= '0;
      end
      rd_v_q  <= mem_en_q;
      valid_q <= rd_v_q && (col_cnt_q >= 2'd2);
      done_q  <= last_shift;
      if (start_acc) begin
        im_q      <= '0;
        ker_q     <= '0;
        col_cnt_q <= 2'd0;
      end else if (rd_v_q) begin
        for (int r = 0; r < 3; r++) begin
          im_q[(3*r)*8 +: 8]    <= im_q[(3*r+1)*8 +: 8];
          im_q[(3*r+1)*8 +: 8]  <= im_q[(3*r+2)*8 +: 8];
          im_q[(3*r+2)*8 +: 8]  <= bus.i_img_data[8*r +: 8];
          ker_q[(3*r)*4 +: 4]   <= ker_q[(3*r+1)*4 +: 4];
          ker_q[(3*r+1)*4 +: 4] <= ker_q[(3*r+2)*4 +: 4];
          ker_q[(3*r+2)*4 +: 4] <= bus.i_wgt_data[8*r +: 4];
        end
        if (col_cnt_q != 2'd3) col_cnt_q <= col_cnt_q + 2'd1;
      end
    end
  end

`ifdef FEEDER_PERF_CNT_EN
  logic [15:0] hold_cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn || start_acc) begin
      hold_cnt_q <= '0;
    end else if (state_q == FETCH && i_hold && hold_cnt_q != 16'hFFFF) begin
      hold_cnt_q <= hold_cnt_q + 16'd1;
    end
  end

  assign o_hold_cycles = hold_cnt_q;
`endif

  // Upper nibble of each weight lane carries no kernel data.
  logic unused_wgt;
  assign unused_wgt = ^{bus.i_wgt_data[23:20], bus.i_wgt_data[15:12], bus.i_wgt_data[7:4]};

  assign o_busy         = (state_q != IDLE);
  assign o_done         = done_q;
  assign bus.o_mem_en   = mem_en_q;
  assign bus.o_mem_addr = mem_addr_q;
  assign bus.o_im       = im_q;
  assign bus.o_ker      = ker_q;
  assign bus.o_valid    = valid_q;

endmodule

// File: tb/tb_mac_window_feeder.sv
// Directed bench for mac_window_feeder with N=8: ramp, hold, mid-frame reset, ignored starts, back-to-back frames.
module tb_mac_window_feeder;
  localparam int N  = 8;
  localparam int AW = 17;

  logic clk = 1'b0;
  logic rstn;
  logic i_start;
  logic i_hold;
  logic o_busy;
  logic o_done;
`ifdef FEEDER_PERF_CNT_EN
  logic [15:0] o_hold_cycles;
`endif
  logic [7:0] img_base;

  int n_checks = 0;
  int n_fail   = 0;

  mac_window_feeder_if #(.AW(AW)) bus ();

  mac_window_feeder #(.N(N), .AW(AW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_start      (i_start),
    .i_hold       (i_hold),
    .o_busy       (o_busy),
    .o_done       (o_done),
`ifdef FEEDER_PERF_CNT_EN
    .o_hold_cycles(o_hold_cycles),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Column memories: image word c = {c+2, c+1, c} + base per lane, fixed kernel word.
  always @(posedge clk) begin
    if (bus.o_mem_en) begin
      bus.i_img_data <= {bus.o_mem_addr[7:0] + 8'd2 + img_base,
                         bus.o_mem_addr[7:0] + 8'd1 + img_base,
                         bus.o_mem_addr[7:0] + img_base};
      bus.i_wgt_data <= 24'h030201;
    end
  end

  task automatic check_eq(input string tag, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [71:0] exp_im(input int j, input logic [7:0] b);
    logic [71:0] v;
    v = '0;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 3; i++)
        v[(3*r+i)*8 +: 8] = 8'(j + i + r) + b;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a frame at E0 and walks edges E1.. until o_done (or a mid-frame reset at rst_at).
  task automatic run_frame(input string tag, input int hold_from, input int hold_n,
                           input int rst_at, input logic [63:0] start_mask,
                           input int exp_done_k, input int exp_a2_k, input logic [7:0] base);
    int acnt[N];
    int vcnt, donek, a2k, firstv;
    vcnt = 0; donek = -1; a2k = -1; firstv = -1;
    foreach (acnt[i]) acnt[i] = 0;
    img_base = base;
    for (int k = 0; k <= 40; k++) begin
      i_start = (k == 0) || start_mask[k];
      i_hold  = (k >= hold_from) && (k < hold_from + hold_n);
      if (k == rst_at) rstn = 1'b0;
      step();
      if (k == rst_at) begin
        i_start = 1'b0;
        i_hold  = 1'b0;
        check_eq({tag, "_rst_ctl"}, {o_busy, o_done, bus.o_mem_en, bus.o_valid}, 0);
        check_eq({tag, "_rst_addr"}, bus.o_mem_addr, 0);
        check_eq({tag, "_rst_im"}, bus.o_im, 0);
        check_eq({tag, "_rst_ker"}, bus.o_ker, 0);
        rstn = 1'b1;
        step();
        check_eq({tag, "_rst_inflight"}, {o_busy, bus.o_mem_en, bus.o_valid, bus.o_im}, 0);
        return;
      end
      if (k == 0) begin
        check_eq({tag, "_e0_busy"}, o_busy, 1);
        check_eq({tag, "_e0_en"}, bus.o_mem_en, 1);
        check_eq({tag, "_e0_addr"}, bus.o_mem_addr, 0);
      end
      if (bus.o_mem_en) begin
        if (bus.o_mem_addr < N) acnt[bus.o_mem_addr]++;
        if (bus.o_mem_addr == 2) a2k = k;
      end
      if (bus.o_valid) begin
        if (firstv < 0) firstv = k;
        check_eq($sformatf("%s_win%0d_im", tag, vcnt), bus.o_im, exp_im(vcnt, base));
        check_eq($sformatf("%s_win%0d_ker", tag, vcnt), bus.o_ker, 72'h333222111);
        vcnt++;
      end
      if (o_done) begin
        donek = k;
        break;
      end
    end
    i_start = 1'b0;
    i_hold  = 1'b0;
    check_eq({tag, "_done_edge"}, donek, exp_done_k);
    check_eq({tag, "_valid_cnt"}, vcnt, N - 2);
    check_eq({tag, "_first_valid"}, firstv, exp_a2_k + 2);
    check_eq({tag, "_addr2_edge"}, a2k, exp_a2_k);
    check_eq({tag, "_busy_at_done"}, o_busy, 0);
    for (int i = 0; i < N; i++)
      check_eq($sformatf("%s_addr%0d_cnt", tag, i), acnt[i], 1);
  endtask

  initial begin
    rstn = 1'b0; i_start = 1'b0; i_hold = 1'b0; img_base = 8'h00;
    bus.i_img_data = '0;
    bus.i_wgt_data = '0;
    repeat (3) step();
    check_eq("reset_ctl", {o_busy, o_done, bus.o_mem_en, bus.o_valid}, 0);
    check_eq("reset_addr", bus.o_mem_addr, 0);
    check_eq("reset_im", bus.o_im, 0);
    check_eq("reset_ker", bus.o_ker, 0);
    rstn = 1'b1;
    step();

    run_frame("ramp", 0, 0, -1, 64'h0, 9, 2, 8'h00);
    repeat (3) step();

    // Hold sampled at E2..E4 pushes address 2 to E5 and o_done to E12.
    run_frame("hold", 2, 3, -1, 64'h0, 12, 5, 8'h00);
    repeat (3) step();

    run_frame("midrst", 0, 0, 5, 64'h0, 0, 0, 8'h10);
    repeat (2) step();
    run_frame("restart", 0, 0, -1, 64'h0, 9, 2, 8'h20);
    repeat (3) step();

    // Starts sampled at E3 (FETCH) and E9 (edge producing o_done) must be ignored.
    run_frame("busy_start", 0, 0, -1, (64'h1 << 3) | (64'h1 << 9), 9, 2, 8'h00);
    repeat (3) step();
    check_eq("busy_start_idle", {o_busy, o_done, bus.o_mem_en, bus.o_valid}, 0);

    run_frame("b2b_f1", 0, 0, -1, 64'h0, 9, 2, 8'h00);
    run_frame("b2b_f2", 0, 0, -1, 64'h0, 9, 2, 8'h40);
    repeat (3) step();

`ifdef FEEDER_PERF_CNT_EN
    run_frame("perf", 2, 5, -1, 64'h0, 14, 7, 8'h00);
    i_hold = 1'b1;
    repeat (2) step();
    i_hold = 1'b0;
    step();
    check_eq("perf_hold_cycles", o_hold_cycles, 5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
